bk_adder: RTL and testbench

- 16-bit Brent-Kung parallel-prefix adder with a registered result.
- Computes Sum/Cout = A + B + Cin through an explicit Brent-Kung carry tree; the behavioural "+" operator is not used for the carry path.
- Used as a datapath adder block and as the Brent-Kung instance in the prefix-adder comparison set.

---
 rtl/bk_adder.sv | 87 ++++++++
 tb/tb_bk_adder.sv | 111 +++++++++++
 2 files changed

// File: rtl/bk_adder.sv
// 16-bit Brent-Kung parallel-prefix adder with one output register stage.
// Cin is folded into the position-0 generate so the tree yields carries directly.

module bk_cell (
  input  logic g_hi,
  input  logic p_hi,
  input  logic g_lo,
  input  logic p_lo,
  output logic g_out,
  output logic p_out
);
  assign g_out = g_hi | (p_hi & g_lo);
  assign p_out = p_hi & p_lo;
endmodule

module bk_adder (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] A,
  input  logic [15:0] B,
  input  logic        Cin,
  output logic [15:0] Sum,
  output logic        Cout
);
  localparam int LEVELS = 7;

  // Distance to the lower operand of the prefix node at (level, bit); 0 = wire through.
  // Levels 1-4 are the up-sweep (spans 2,4,8,16), levels 5-7 the down-sweep.
  function automatic int node_dist(input int lvl, input int i);
    node_dist = 0;
    case (lvl)
      1: if (i % 2 == 1) node_dist = 1;
      2: if (i % 4 == 3) node_dist = 2;
      3: if (i % 8 == 7) node_dist = 4;
      4: if (i == 15) node_dist = 8;
      5: if (i == 11) node_dist = 4;
      6: if (i == 5 || i == 9 || i == 13) node_dist = 2;
      7: if (i % 2 == 0 && i >= 2) node_dist = 1;
      default: node_dist = 0;
    endcase
  endfunction

  logic [LEVELS:0][15:0] gl;
  logic [LEVELS:0][15:0] pl;
  logic [15:0]           p;
  logic [16:0]           c;

  assign p           = A ^ B;
  assign gl[0][0]    = (A[0] & B[0]) | (p[0] & Cin);
  assign gl[0][15:1] = A[15:1] & B[15:1];
  assign pl[0]       = p;

  genvar l, i;
  generate
    for (l = 1; l <= LEVELS; l++) begin : g_lvl
      for (i = 0; i < 16; i++) begin : g_bit
        localparam int D = node_dist(l, i);
        if (D != 0) begin : g_node
          bk_cell u_cell (
            .g_hi (gl[l-1][i]),
            .p_hi (pl[l-1][i]),
            .g_lo (gl[l-1][i-D]),
            .p_lo (pl[l-1][i-D]),
            .g_out(gl[l][i]),
            .p_out(pl[l][i])
          );
        end else begin : g_pass
          assign gl[l][i] = gl[l-1][i];
          assign pl[l][i] = pl[l-1][i];
        end
      end
    end
  endgenerate

  // After the down-sweep every gl[7][i] is the full group generate [i:0] including Cin.
  assign c = {gl[LEVELS], Cin};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum  <= 16'h0000;
      Cout <= 1'b0;
    end else begin
      Sum  <= p ^ c[15:0];
      Cout <= c[16];
    end
  end
endmodule

// File: tb/tb_bk_adder.sv
// Self-checking bench for bk_adder: directed table, reset corners, carry chains, random stream.
module tb_bk_adder;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] A = '0, B = '0;
  logic        Cin = 1'b0;
  logic [15:0] Sum;
  logic        Cout;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec_t;

  vec_t        tbl[8];
  logic [16:0] sb[$];
  int          n_vec = 0;
  int          n_err = 0;

  bk_adder dut (
    .clk (clk),
    .rst (rst),
    .A   (A),
    .B   (B),
    .Cin (Cin),
    .Sum (Sum),
    .Cout(Cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {Cout,Sum}=%h expected %h", name, act, exp);
    end
  endtask

  // Drive one vector at the falling edge, push its expected result, compare after the next rising edge.
  task automatic apply(input string name, input logic [15:0] a, input logic [15:0] b,
                       input logic cin, input logic [16:0] exp);
    logic [16:0] e;
    @(negedge clk);
    A = a; B = b; Cin = cin;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++; n_err++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(name, {Cout, Sum}, e);
    end
  endtask

  initial begin
    tbl[0] = '{16'h0000, 16'h1111, 1'b0, 17'h01111};
    tbl[1] = '{16'h1111, 16'h0000, 1'b0, 17'h01111};
    tbl[2] = '{16'h0101, 16'h0000, 1'b1, 17'h00102};
    tbl[3] = '{16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
    tbl[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    tbl[5] = '{16'hFFFF, 16'h0000, 1'b0, 17'h0FFFF};
    tbl[6] = '{16'hFFFF, 16'h0000, 1'b1, 17'h10000};
    tbl[7] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};

    // Reset asserted between edges must clear outputs right away and hold them across edges.
    #1 rst = 1'b1;
    #1 check("reset_async", {Cout, Sum}, 17'h00000);
    A = 16'hFFFF; B = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1 check("reset_hold", {Cout, Sum}, 17'h00000);
    @(negedge clk) rst = 1'b0;

    for (int k = 0; k < 8; k++)
      apply($sformatf("table%0d", k), tbl[k].a, tbl[k].b, tbl[k].cin, tbl[k].exp);

    // Mid-cycle reset with all-ones operands loaded, then first capture after release.
    apply("pre_reset", 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE);
    #2 rst = 1'b1;
    #1 check("reset_midcycle", {Cout, Sum}, 17'h00000);
    @(negedge clk) rst = 1'b0;
    apply("post_reset", 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE);

    for (int k = 1; k <= 16; k++) begin
      logic [16:0] t;
      t = (17'd1 << k) - 17'd1;
      apply($sformatf("chain%0d", k), t[15:0], 16'h0001, 1'b0, 17'd1 << k);
    end

    for (int n = 0; n < 10000; n++) begin
      logic [15:0] a, b;
      logic        ci;
      a  = 16'($urandom);
      b  = 16'($urandom);
      ci = 1'($urandom);
      apply("random", a, b, ci, {1'b0, a} + {1'b0, b} + {16'b0, ci});
    end

    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL scoreboard_drain: got %0d left expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
